// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: monitor FSM state encoding
// and default window / lock-hold lengths used by the PRBS blocks.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOCK,
    MEASURE,
    DONE
  } state_e;

  localparam int unsigned DEF_WIN_LEN   = 1000000;
  localparam int unsigned DEF_LOCK_HOLD = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async low), clr, en -> count[W-1:0], sat (count at max).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sat
);

  // Once all-ones the counter never moves again until cleared,
  // so the saturation flag can be taken straight from the value.
  assign sat = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs_ber_monitor.sv
// Bit-error-rate window monitor fed by the PRBS checker lock/bit_error.
// Ports: Clock_M, Reset (async low), start, lock, bit_error ->
//   busy, done, lock_lost, bit_count[CNT_W], err_count[ERR_W], err_sat.
module prbs_ber_monitor
  import prbs_pkg::*;
#(
  parameter int unsigned WIN_LEN   = DEF_WIN_LEN,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned ERR_W     = 16,
  parameter int unsigned LOCK_HOLD = DEF_LOCK_HOLD
) (
  input  logic             Clock_M,
  input  logic             Reset,
  input  logic             start,
  input  logic             lock,
  input  logic             bit_error,
  output logic             busy,
  output logic             done,
  output logic             lock_lost,
  output logic [CNT_W-1:0] bit_count,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat
);

  localparam int unsigned HOLD_W = $clog2(LOCK_HOLD + 1);

  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(WIN_LEN - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD =
    HOLD_W'(LOCK_HOLD - 1);

  state_e            state_q;
  state_e            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  bit_q;
  logic              lost_q;

  logic accept;
  logic counting;
  logic last_bit;
  logic hold_hit;
  logic drop;

  assign accept   = (state_q == IDLE) && start;
  assign counting = (state_q == MEASURE) && lock;
  assign drop     = (state_q == MEASURE) && !lock;
  assign last_bit = counting && (bit_q == LAST_BIT);
  assign hold_hit = (state_q == WAIT_LOCK) && lock &&
                    (hold_q == LAST_HOLD);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        busy = 1'b1;
        if (hold_hit) state_d = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        // lock loss takes priority over the final count
        if (drop || last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_M or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      bit_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_q <= '0;
        bit_q  <= '0;
        lost_q <= 1'b0;
      end
      if (state_q == WAIT_LOCK) begin
        hold_q <= lock ? hold_q + HOLD_W'(1) : '0;
      end
      if (counting) begin
        bit_q <= bit_q + CNT_W'(1);
      end
      if (drop) begin
        lost_q <= 1'b1;
      end
    end
  end

  // Errors only advance alongside a counted bit, which keeps
  // err_count <= bit_count.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (Clock_M),
    .rst_n (Reset),
    .clr   (accept),
    .en    (counting && bit_error),
    .count (err_count),
    .sat   (err_sat)
  );

  assign bit_count = bit_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_prbs_ber_monitor.sv
// Scoreboard bench for prbs_ber_monitor with a short window.
// Expected window results are queued at start and popped at done.
module tb_prbs_ber_monitor;

  localparam int WIN  = 100;
  localparam int HOLD = 4;
  localparam int EW   = 4;
  localparam int CW   = 32;

  logic          Clock_M   = 1'b0;
  logic          Reset     = 1'b0;
  logic          start     = 1'b0;
  logic          lock      = 1'b1;
  logic          bit_error = 1'b0;
  logic          busy;
  logic          done;
  logic          lock_lost;
  logic [CW-1:0] bit_count;
  logic [EW-1:0] err_count;
  logic          err_sat;

  typedef struct {
    logic [CW-1:0] bits;
    logic [EW-1:0] errs;
    logic          lost;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   done_cnt = 0;

  prbs_ber_monitor #(
    .WIN_LEN   (WIN),
    .CNT_W     (CW),
    .ERR_W     (EW),
    .LOCK_HOLD (HOLD)
  ) dut (
    .Clock_M   (Clock_M),
    .Reset     (Reset),
    .start     (start),
    .lock      (lock),
    .bit_error (bit_error),
    .busy      (busy),
    .done      (done),
    .lock_lost (lock_lost),
    .bit_count (bit_count),
    .err_count (err_count),
    .err_sat   (err_sat)
  );

  always #5 Clock_M = ~Clock_M;

  always @(negedge Clock_M) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge Clock_M);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic exp_t mk(input int b, input int e,
                              input bit l, input bit s);
    exp_t x;
    x.bits = CW'(b);
    x.errs = EW'(e);
    x.lost = l;
    x.sat  = s;
    return x;
  endfunction

  // Drives one run that has just been started. pre = WAIT_LOCK
  // cycles before the first measured bit; wl_pat gives lock for the
  // first wl_len of them; emask[k] is bit_error on measured bit k;
  // drop_at drops lock on bit k; start_at re-pulses start on bit k.
  task automatic run_meas(input int pre,
                          input logic [7:0] wl_pat,
                          input int wl_len,
                          input logic [127:0] emask,
                          input int drop_at,
                          input int start_at,
                          output int cyc,
                          output bit seen,
                          output int first_sat,
                          output int viol);
    int k;
    cyc = 0; seen = 0; first_sat = 0; viol = 0;
    while (!seen && cyc < 400) begin
      k = cyc + 1 - pre;
      lock = 1'b1; bit_error = 1'b0; start = 1'b0;
      if (k < 1) begin
        if (cyc < wl_len) lock = wl_pat[cyc];
      end else begin
        if (k < 128) bit_error = emask[k];
        if (k == drop_at) begin
          lock = 1'b0;
          bit_error = 1'b1;
        end
        if (k == start_at) start = 1'b1;
      end
      tick();
      cyc++;
      if (done === 1'b1) seen = 1;
      if (err_count > bit_count) viol++;
      if (err_sat === 1'b1 && first_sat == 0) first_sat = k;
    end
    lock = 1'b1; bit_error = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({busy, done, lock_lost, err_sat} !== 4'b0)
      $display("FAIL rst_flags: got %b want 0000",
               {busy, done, lock_lost, err_sat});
    else n_pass++;
    n_total++;
    if (bit_count !== '0 || err_count !== '0)
      $display("FAIL rst_counts: got %0d/%0d want 0/0",
               bit_count, err_count);
    else n_pass++;
    Reset = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL rst_idle_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_clean();
    int cyc, fs, viol; bit seen; exp_t e;
    sb.push_back(mk(WIN, 0, 0, 0));
    pulse_start();
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL clean_busy: got %b want 1", busy);
    else n_pass++;
    run_meas(HOLD, 8'h00, 0, '0, 0, 0, cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen || cyc != HOLD + WIN)
      $display("FAIL clean_latency: got %0d seen=%0d want %0d",
               cyc, seen, HOLD + WIN);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL clean_busy_done: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (bit_count !== e.bits || err_count !== e.errs)
      $display("FAIL clean_counts: got %0d/%0d want %0d/%0d",
               bit_count, err_count, e.bits, e.errs);
    else n_pass++;
    n_total++;
    if (lock_lost !== e.lost || err_sat !== e.sat)
      $display("FAIL clean_flags: got %b%b want %b%b",
               lock_lost, err_sat, e.lost, e.sat);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || bit_count !== e.bits)
      $display("FAIL clean_after: done=%b bits=%0d want 0/%0d",
               done, bit_count, e.bits);
    else n_pass++;
  endtask

  task automatic test_errors();
    int cyc, fs, viol; bit seen; exp_t e;
    logic [127:0] m;
    int pos[7] = '{1, 2, 17, 50, 51, 99, 100};
    m = '0;
    foreach (pos[i]) m[pos[i]] = 1'b1;
    sb.push_back(mk(WIN, 7, 0, 0));
    pulse_start();
    run_meas(HOLD, 8'h00, 0, m, 0, 0, cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen)
      $display("FAIL err_timeout: got no done want done");
    else n_pass++;
    n_total++;
    if (bit_count !== e.bits || err_count !== e.errs)
      $display("FAIL err_counts: got %0d/%0d want %0d/%0d",
               bit_count, err_count, e.bits, e.errs);
    else n_pass++;
    n_total++;
    if (lock_lost !== e.lost || err_sat !== e.sat)
      $display("FAIL err_flags: got %b%b want %b%b",
               lock_lost, err_sat, e.lost, e.sat);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturate();
    int cyc, fs, viol; bit seen; exp_t e;
    sb.push_back(mk(WIN, 15, 0, 1));
    pulse_start();
    run_meas(HOLD, 8'h00, 0, {128{1'b1}}, 0, 0,
             cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen || bit_count !== e.bits)
      $display("FAIL sat_bits: got %0d seen=%0d want %0d",
               bit_count, seen, e.bits);
    else n_pass++;
    n_total++;
    if (err_count !== e.errs || err_sat !== e.sat)
      $display("FAIL sat_errs: got %0d/%b want %0d/%b",
               err_count, err_sat, e.errs, e.sat);
    else n_pass++;
    n_total++;
    if (fs != 15)
      $display("FAIL sat_first: got bit %0d want bit 15", fs);
    else n_pass++;
    n_total++;
    if (viol != 0)
      $display("FAIL sat_err_le_bits: got %0d want 0", viol);
    else n_pass++;
    tick();
  endtask

  task automatic test_lock_loss();
    int cyc, fs, viol; bit seen; exp_t e;
    logic [127:0] m;
    m = '0;
    m[5] = 1'b1;
    sb.push_back(mk(40, 1, 1, 0));
    pulse_start();
    run_meas(HOLD + 3, 8'h7B, 7, m, 41, 0, cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen || cyc != HOLD + 3 + 41)
      $display("FAIL loss_latency: got %0d seen=%0d want %0d",
               cyc, seen, HOLD + 3 + 41);
    else n_pass++;
    n_total++;
    if (bit_count !== e.bits || err_count !== e.errs)
      $display("FAIL loss_counts: got %0d/%0d want %0d/%0d",
               bit_count, err_count, e.bits, e.errs);
    else n_pass++;
    n_total++;
    if (lock_lost !== e.lost || err_sat !== e.sat)
      $display("FAIL loss_flags: got %b%b want %b%b",
               lock_lost, err_sat, e.lost, e.sat);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || lock_lost !== 1'b1)
      $display("FAIL loss_hold: done=%b lost=%b want 0/1",
               done, lock_lost);
    else n_pass++;
  endtask

  task automatic test_start_ignore();
    int cyc, fs, viol, d0; bit seen; exp_t e;
    logic [127:0] m;
    m = '0;
    m[3] = 1'b1;
    m[10] = 1'b1;
    d0 = done_cnt;
    sb.push_back(mk(29, 2, 1, 0));
    pulse_start();
    run_meas(HOLD, 8'h00, 0, m, 30, 10, cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen || cyc != HOLD + 30)
      $display("FAIL ign_latency: got %0d seen=%0d want %0d",
               cyc, seen, HOLD + 30);
    else n_pass++;
    n_total++;
    if (bit_count !== e.bits || err_count !== e.errs ||
        lock_lost !== e.lost)
      $display("FAIL ign_counts: got %0d/%0d/%b want %0d/%0d/%b",
               bit_count, err_count, lock_lost,
               e.bits, e.errs, e.lost);
    else n_pass++;
    start = 1'b1;
    tick();
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ign_done_start: busy=%b done=%b want 0/0",
               busy, done);
    else n_pass++;
    sb.push_back(mk(WIN, 0, 0, 0));
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || lock_lost !== 1'b0)
      $display("FAIL ign_restart: busy=%b lost=%b want 1/0",
               busy, lock_lost);
    else n_pass++;
    n_total++;
    if (bit_count !== '0 || err_count !== '0)
      $display("FAIL ign_cleared: got %0d/%0d want 0/0",
               bit_count, err_count);
    else n_pass++;
    n_total++;
    if (done_cnt - d0 != 1)
      $display("FAIL ign_single_done: got %0d pulses want 1",
               done_cnt - d0);
    else n_pass++;
    run_meas(HOLD, 8'h00, 0, '0, 0, 0, cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen || bit_count !== e.bits || err_count !== e.errs)
      $display("FAIL ign_rerun: got %0d/%0d seen=%0d want %0d/%0d",
               bit_count, err_count, seen, e.bits, e.errs);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    int cyc, fs, viol, d0; bit seen; exp_t e;
    logic [127:0] m;
    d0 = done_cnt;
    pulse_start();
    bit_error = 1'b1;
    repeat (HOLD + 55) tick();
    bit_error = 1'b0;
    n_total++;
    if (bit_count !== CW'(55) || err_sat !== 1'b1)
      $display("FAIL ares_pre: got %0d/%b want 55/1",
               bit_count, err_sat);
    else n_pass++;
    #3;
    Reset = 1'b0;
    #1;
    n_total++;
    if ({busy, done, lock_lost, err_sat} !== 4'b0 ||
        bit_count !== '0 || err_count !== '0)
      $display("FAIL ares_clear: got %b %0d/%0d want 0000 0/0",
               {busy, done, lock_lost, err_sat},
               bit_count, err_count);
    else n_pass++;
    repeat (3) tick();
    Reset = 1'b1;
    repeat (2) tick();
    n_total++;
    if (done_cnt != d0 || busy !== 1'b0)
      $display("FAIL ares_no_done: pulses=%0d busy=%b want 0/0",
               done_cnt - d0, busy);
    else n_pass++;
    m = '0;
    m[100] = 1'b1;
    sb.push_back(mk(WIN, 1, 0, 0));
    pulse_start();
    run_meas(HOLD, 8'h00, 0, m, 0, 0, cyc, seen, fs, viol);
    e = sb.pop_front();
    n_total++;
    if (!seen || cyc != HOLD + WIN)
      $display("FAIL ares_latency: got %0d seen=%0d want %0d",
               cyc, seen, HOLD + WIN);
    else n_pass++;
    n_total++;
    if (bit_count !== e.bits || err_count !== e.errs ||
        lock_lost !== e.lost || err_sat !== e.sat)
      $display("FAIL ares_result: got %0d/%0d/%b%b want %0d/%0d/%b%b",
               bit_count, err_count, lock_lost, err_sat,
               e.bits, e.errs, e.lost, e.sat);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_errors();
    test_saturate();
    test_lock_loss();
    test_start_ignore();
    test_async_reset();
    n_total++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
